// File: rtl/udc_mon_pkg.sv
// Shared state type, default widths and the saturating next-count helper for the counter monitor.
// Latency: none (types and functions only). Backpressure: none.
// Dwell tracking in the monitor is enabled by defining UDC_MON_DWELL_EN.
package udc_mon_pkg;

  localparam int UDC_SIZE    = 4;
  localparam int UDC_DWELL_W = 8;
  localparam logic [31:0] UDC_MAX = (32'd1 << UDC_SIZE) - 32'd1;

  typedef enum logic [2:0] {
    INIT,
    TRACK,
    SAT_HI,
    SAT_LO,
    FAULT
  } udc_mon_state_t;

  // Next count the counter must produce; max_v lets wider instances reuse it.
  function automatic logic [31:0] udc_expected(input logic [31:0] prev,
                                               input logic        dir,
                                               input logic [31:0] max_v = UDC_MAX);
    logic [31:0] nxt;
    nxt = prev;
    if (dir) begin
      if (prev != max_v) nxt = prev + 32'd1;
    end else begin
      if (prev != 32'd0) nxt = prev - 32'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/udc_dwell_ctr.sv
// Saturating cycle counter: counts while inc is high, clears on clr (clr wins).
// Latency: 1 cycle, registered output. Backpressure: none, sticks at all-ones.
module udc_dwell_ctr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/updown_count_monitor.sv
// Checks a saturating up/down counter each edge; pulses legal steps, flags illegal ones (sticky err).
// Latency: flags for the sample seen at an edge are registered out on that edge. Backpressure: none.
// UDC_MON_DWELL_EN adds the saturation dwell counter; otherwise dwell_cnt is tied to 0.
module updown_count_monitor
  import udc_mon_pkg::*;
#(
  parameter int SIZE    = UDC_SIZE,
  parameter int DWELL_W = UDC_DWELL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SIZE-1:0]    count_in,
  input  logic               up_down,
  input  logic               err_clr,
  output logic               step_up,
  output logic               step_dn,
  output logic               hold,
  output logic               at_max,
  output logic               at_min,
  output logic               err,
  output logic [DWELL_W-1:0] dwell_cnt
);

  localparam logic [SIZE-1:0] CNT_MAX = '1;

  udc_mon_state_t  state_q, state_nx, tgt_state;
  logic [SIZE-1:0] prev_cnt;
  logic            prev_dir;
  logic [SIZE-1:0] exp_cnt;
  logic            up_nx, dn_nx, hold_nx, err_nx;

  assign exp_cnt = SIZE'(udc_expected(32'(prev_cnt), prev_dir, 32'(CNT_MAX)));

  assign tgt_state = (count_in == CNT_MAX) ? SAT_HI :
                     (count_in == '0)      ? SAT_LO : TRACK;

  always_comb begin
    state_nx = state_q;
    up_nx    = 1'b0;
    dn_nx    = 1'b0;
    hold_nx  = 1'b0;
    err_nx   = err;
    case (state_q)
      INIT: begin
        state_nx = tgt_state;
        if (err_clr) err_nx = 1'b0;
      end
      TRACK, SAT_HI, SAT_LO: begin
        if (count_in == exp_cnt) begin
          state_nx = tgt_state;
          up_nx    = (count_in != prev_cnt) && prev_dir;
          dn_nx    = (count_in != prev_cnt) && !prev_dir;
          hold_nx  = (count_in == prev_cnt);
          if (err_clr) err_nx = 1'b0;
        end else begin
          // A mismatch beats a simultaneous err_clr.
          state_nx = FAULT;
          err_nx   = 1'b1;
        end
      end
      FAULT: begin
        if (err_clr) begin
          state_nx = INIT;
          err_nx   = 1'b0;
        end
      end
      default: state_nx = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= INIT;
      prev_cnt <= '0;
      prev_dir <= 1'b0;
      step_up  <= 1'b0;
      step_dn  <= 1'b0;
      hold     <= 1'b0;
      at_max   <= 1'b0;
      at_min   <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_q  <= state_nx;
      prev_cnt <= count_in;
      prev_dir <= up_down;
      step_up  <= up_nx;
      step_dn  <= dn_nx;
      hold     <= hold_nx;
      at_max   <= (state_nx == SAT_HI);
      at_min   <= (state_nx == SAT_LO);
      err      <= err_nx;
    end
  end

`ifdef UDC_MON_DWELL_EN
  logic sat_nx, dwell_inc, dwell_clr;

  assign sat_nx    = (state_nx == SAT_HI) || (state_nx == SAT_LO);
  assign dwell_inc = sat_nx && (state_nx == state_q);
  assign dwell_clr = !sat_nx;

  udc_dwell_ctr #(
    .W (DWELL_W)
  ) u_dwell (
    .clk (clk),
    .rst (rst),
    .inc (dwell_inc),
    .clr (dwell_clr),
    .cnt (dwell_cnt)
  );
`else
  assign dwell_cnt = '0;
`endif

endmodule

// File: tb/tb_updown_count_monitor.sv
// Scoreboard bench for updown_count_monitor: driver pushes model expectations, monitor pops and compares.
// Latency checked: one edge per sample. Backpressure: not applicable.
module tb_updown_count_monitor;

  localparam int PH_INIT  = 0;
  localparam int PH_CHECK = 1;
  localparam int PH_FAULT = 2;
`ifdef UDC_MON_DWELL_EN
  localparam bit DWELL_ON = 1'b1;
`else
  localparam bit DWELL_ON = 1'b0;
`endif

  typedef struct packed {
    logic       up;
    logic       dn;
    logic       hold;
    logic       amax;
    logic       amin;
    logic       err;
    logic [7:0] dwell;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] count_in = 4'd0;
  logic       up_down = 1'b0;
  logic       err_clr = 1'b0;
  logic       step_up, step_dn, hold, at_max, at_min, err;
  logic [7:0] dwell_cnt;

  int tests = 0;
  int fails = 0;
  int n_pop = 0;
  bit done = 1'b0;

  exp_t exp_q[$];

  // Reference model state
  int m_phase = PH_INIT;
  int m_prev  = 0;
  int m_dir   = 0;
  int m_dwell = 0;
  bit m_hi    = 1'b0;
  bit m_lo    = 1'b0;
  int cur     = 0;

  updown_count_monitor dut (
    .clk       (clk),
    .rst       (rst),
    .count_in  (count_in),
    .up_down   (up_down),
    .err_clr   (err_clr),
    .step_up   (step_up),
    .step_dn   (step_dn),
    .hold      (hold),
    .at_max    (at_max),
    .at_min    (at_min),
    .err       (err),
    .dwell_cnt (dwell_cnt)
  );

  always #5 clk = ~clk;

  function automatic exp_t act_vec();
    exp_t a;
    a.up    = step_up;
    a.dn    = step_dn;
    a.hold  = hold;
    a.amax  = at_max;
    a.amin  = at_min;
    a.err   = err;
    a.dwell = dwell_cnt;
    return a;
  endfunction

  // Monitor: one registered output set per clock edge after each driven sample.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e, a;
        e = exp_q.pop_front();
        a = act_vec();
        n_pop++;
        tests++;
        if (a !== e) begin
          fails++;
          $display("FAIL outputs@sample%0d: got up=%b dn=%b hold=%b max=%b min=%b err=%b dwell=%0d, want up=%b dn=%b hold=%b max=%b min=%b err=%b dwell=%0d",
                   n_pop, a.up, a.dn, a.hold, a.amax, a.amin, a.err, a.dwell,
                   e.up, e.dn, e.hold, e.amax, e.amin, e.err, e.dwell);
        end
      end
    end
  end

  function automatic int sat_next(input int c, input int d);
    if (d != 0) return (c >= 15) ? 15 : c + 1;
    return (c <= 0) ? 0 : c - 1;
  endfunction

  // Present one sample on a negedge, record what the monitor must report after the next edge.
  task automatic drive(input int c, input int d, input bit clr);
    exp_t e;
    int   want;
    count_in = 4'(c);
    up_down  = (d != 0);
    err_clr  = clr;
    e = '0;
    case (m_phase)
      PH_INIT: begin
        e.amax  = (c == 15);
        e.amin  = (c == 0);
        m_dwell = 0;
        m_phase = PH_CHECK;
      end
      PH_CHECK: begin
        want = sat_next(m_prev, m_dir);
        if (c == want) begin
          e.up   = (c > m_prev);
          e.dn   = (c < m_prev);
          e.hold = (c == m_prev);
          e.amax = (c == 15);
          e.amin = (c == 0);
          if ((e.amax && m_hi) || (e.amin && m_lo))
            m_dwell = (m_dwell >= 255) ? 255 : m_dwell + 1;
          else
            m_dwell = 0;
        end else begin
          e.err   = 1'b1;
          m_dwell = 0;
          m_phase = PH_FAULT;
        end
      end
      default: begin
        e.err   = !clr;
        m_dwell = 0;
        if (clr) m_phase = PH_INIT;
      end
    endcase
    m_hi    = e.amax;
    m_lo    = e.amin;
    e.dwell = DWELL_ON ? 8'(m_dwell) : 8'd0;
    m_prev  = c;
    m_dir   = d;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Counter-model step: the sample is the current count, next count follows the contract.
  task automatic legal(input int d);
    drive(cur, d, 1'b0);
    cur = sat_next(cur, d);
  endtask

  task automatic inject(input int bad, input int d, input bit clr);
    drive(bad, d, clr);
    cur = sat_next(bad, d);
  endtask

  task automatic check_zero(input string name);
    exp_t a;
    a = act_vec();
    tests++;
    if (a !== '0) begin
      fails++;
      $display("FAIL %s: got outputs=%h, want 0", name, a);
    end
  endtask

  // Called on a negedge; returns on a negedge with reset released.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    check_zero("async_reset");
    exp_q.delete();
    m_phase = PH_INIT;
    m_prev  = 0;
    m_dir   = 0;
    m_dwell = 0;
    m_hi    = 1'b0;
    m_lo    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #2 rst = 1'b0;
    #1 check_zero("reset_state");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Full climb 0..F, then sit at F holding up
    cur = 0;
    for (int i = 0; i < 16; i++) legal(1);
    for (int i = 0; i < 21; i++) legal(1);

    // Down to 5, then an illegal jump 5 -> 7
    while (cur != 5) legal(0);
    legal(1);
    inject(7, 1, 1'b0);
    for (int i = 0; i < 3; i++) legal(1);

    // Clear at count 3, then legal steps resume
    inject(3, 1, 1'b1);
    for (int i = 0; i < 4; i++) legal(1);
    for (int i = 0; i < 3; i++) legal(0);

    // Wrap 0 -> F is illegal, plus mismatch coinciding with err_clr
    while (cur != 0) legal(0);
    legal(0);
    inject(15, 0, 1'b0);
    inject(8, 0, 1'b1);
    legal(0);
    inject(2, 1, 1'b1);
    inject(9, 1, 1'b0);

    // Reset mid-run at count 9
    cur = 9;
    while (cur != 9) legal(1);
    legal(1);
    legal(0);
    cur = 9;
    do_reset();
    cur = 4;
    for (int i = 0; i < 5; i++) legal(1);

    // Randomized traffic with occasional faults, clears and resets
    for (int i = 0; i < 500; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 4) begin
        inject($urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 3) == 0);
      end else if (r < 10) begin
        drive(cur, 0, 1'b1);
        cur = sat_next(cur, 0);
      end else if (r == 10) begin
        do_reset();
      end else begin
        // Bias direction so the counter dwells at both rails
        legal(($urandom_range(0, 99) < ((i / 60) % 2 == 0 ? 80 : 20)) ? 1 : 0);
      end
    end

    err_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    if (!done) begin
      $display("FAIL timeout: got no completion by 200000, want completion");
      $fatal(1, "timeout");
    end
  end

endmodule

// File: doc/updown_count_monitor.md
# updown_count_monitor

Checking receiver for the 4-bit saturating up/down counter. Every cycle it samples the counter's `count` and the `up_down` command that produced it, decodes each step as up, down or hold, and tracks saturation at 0 and max. It flags any transition the counter contract does not permit. It sits beside the counter in the datapath, as the consumer of the counter's outputs, and feeds status and error flags to the control logic.

## Interface
- `SIZE`, 4, width of the observed count
- `DWELL_W`, 8, width of the saturation dwell counter
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `count_in`  in  SIZE  counter output, sampled every edge
- `up_down`  in  1  counter direction command, same-edge sample (1 = up)
- `err_clr`  in  1  clears the sticky error and resynchronises
- `step_up`  out  1  one-cycle pulse, legal increment seen
- `step_dn`  out  1  one-cycle pulse, legal decrement seen
- `hold`  out  1  one-cycle pulse, legal saturated hold seen
- `at_max` / `at_min`  out  1  level flags, state is SAT_HI / SAT_LO
- `err`  out  1  sticky, illegal transition detected
- `dwell_cnt`  out  DWELL_W  consecutive cycles spent saturated (macro-gated)

## Operation
- Registers `prev_cnt` and `prev_dir` each edge, taking them from `count_in` and `up_down`.
- Expected next count:
  - `prev_dir`=1: `prev_cnt`+1, or `prev_cnt` when `prev_cnt` = 2^SIZE−1.
  - `prev_dir`=0: `prev_cnt`−1, or `prev_cnt` when `prev_cnt` = 0.
- Arithmetic is SIZE bits. Wrap-around (F→0 or 0→F) is always illegal.
- States: INIT, TRACK, SAT_HI, SAT_LO, FAULT.
  - INIT: capture only, no pulses; go to TRACK, SAT_HI or SAT_LO according to `count_in`.
  - TRACK / SAT_*: when `count_in` equals the expected count, pulse `step_up`, `step_dn` or `hold`, then take the next state from `count_in` (max → SAT_HI, 0 → SAT_LO, else TRACK). When it differs, set `err` and go to FAULT.
  - FAULT: all pulses suppressed; `prev_*` keeps updating. `err_clr` → INIT.
- `hold` with `count_in` ≠ 0 and ≠ max is impossible. Any such transition is a mismatch and goes to FAULT.
- `err_clr` outside FAULT clears `err` (no effect if already clear) and does not change state.
- `err_clr` on the same edge as a new mismatch: the mismatch wins, so `err` stays 1 and the state goes to FAULT.
- Reset mid-operation: every output goes to 0 immediately and the state goes to INIT. The first sample after release is never checked.

## Timing
- All outputs are registered. The flag for the count observed at edge k+1 (produced by `up_down` at edge k) is valid after edge k+1.
- Pulses last exactly one cycle per observed step; there is no extra latency.
- Reset values:
  - `step_up`, `step_dn`, `hold`, `at_max`, `at_min`, `err` = 0; `dwell_cnt` = 0.
  - `prev_cnt` = 0, `prev_dir` = 0, state = INIT.
- `at_max` / `at_min` change on the same edge as the state transition.

## Configuration
- `UDC_MON_DWELL_EN` defined:
  - `dwell_cnt` increments each cycle the state stays in SAT_HI or SAT_LO and saturates at 2^DWELL_W−1.
  - It clears to 0 on entering TRACK, INIT or FAULT.
  - A direct SAT_HI↔SAT_LO change is illegal, so it cannot occur.
- Undefined: `dwell_cnt` is tied to 0 and no dwell register is synthesised.

## Structure
- Package `udc_mon_pkg` holds:
  - the state enum `udc_mon_state_t` (INIT, TRACK, SAT_HI, SAT_LO, FAULT);
  - the default `SIZE` and `DWELL_W` constants;
  - the function `udc_expected(prev, dir)` returning the saturating next count.
- One sub-module, `udc_dwell_ctr`: a saturating counter with `inc` and `clr` inputs, instantiated only under the macro.

## Test plan
- Reset, then `count_in` 0 with `up_down`=1 for 16 cycles (counter model) → `at_min` on the first checked cycle, then 15 `step_up` pulses, then `hold` and `at_max` when the count sits at F; `err`=0 throughout.
- Count at F, `up_down`=1 held for 20 cycles → `hold` every cycle; `dwell_cnt` reaches 20 (macro on) or stays 0 (macro off).
- Count 5, `up_down`=1, next sample forced to 7 → `err`=1 one cycle later, state FAULT, no further pulses.
- FAULT, then `err_clr` pulse with count 3 → INIT, no pulse on the next cycle, legal steps from 3 pulse again, `err`=0.
- Count 0, `up_down`=0, next sample forced to F (wrap) → `err`=1.
- Assert `rst` low mid-run at count 9 → all outputs 0 immediately; after release, the first sample produces no pulse and no error.
